dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory port. Replaces the

---
 rtl/dmem_responder.sv | 80 ++++++++
 tb/tb_dmem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with programmable wait states and error flagging
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam bit ZL = LATENCY == 0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0] lat_be;
  logic [31:0] mem [DEPTH];
  logic accept, access, a_we, err;
  logic [31:0] a_addr, a_wdata;
  logic [3:0] a_be;
  logic [AW-1:0] idx;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept     = req_valid & req_ready;
  // with zero wait states the access happens on the accept edge straight from the request
  assign access  = ZL ? accept : (state == WAIT && cnt == 4'd1);
  assign a_we    = ZL ? req_we : lat_we;
  assign a_addr  = ZL ? req_addr : lat_addr;
  assign a_wdata = ZL ? req_wdata : lat_wdata;
  assign a_be    = ZL ? req_be : lat_be;
  assign idx     = a_addr[AW+1:2];
  assign err     = (|a_addr[1:0]) | (|a_addr[31:AW+2]);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (ZL ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
              (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        cnt       <= 4'(LATENCY);
      end
      if (state == WAIT) cnt <= cnt - 4'd1;
      if (access) begin
        resp_err   <= err;
        resp_rdata <= (err | a_we) ? '0 : mem[idx];
        if (!err && a_we)
          for (int b = 0; b < 4; b++)
            if (a_be[b]) mem[idx][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized check of a LATENCY=2 and a LATENCY=0 responder against a word-array model
module tb_dmem_responder;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0] req_be [2];
  logic [31:0] resp_rdata [2];
  logic [31:0] mdl [2][DEPTH];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mdl[d][i] = '0;
  endtask
  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall, input logic hold);
    int n;
    int lat;
    logic e;
    logic [31:0] exp_r, r0;
    lat = (d == 0) ? 2 : 0;
    e = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
    exp_r = (e || we) ? 32'h0 : mdl[d][addr / 4];
    if (!e && we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[d][addr / 4][8*b +: 8] = wdata[8*b +: 8];
    @(negedge clk);
    check("rdy_idle", 32'(req_ready[d]), 1);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = hold;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      check("rdy_wait", 32'(req_ready[d]), 0);
      @(negedge clk);
      n++;
    end
    check("lat", 32'(n), 32'(lat + 1));
    check("rdata", resp_rdata[d], exp_r);
    check("err", 32'(resp_err[d]), 32'(e));
    r0 = resp_rdata[d];
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[d]), 1);
      check("hold_rdata", resp_rdata[d], r0);
      check("rdy_resp", 32'(req_ready[d]), 0);
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("valid_drop", 32'(resp_valid[d]), 0);
    check("rdy_back", 32'(req_ready[d]), 1);
  endtask
  initial begin
    int cnt;
    logic [31:0] a;
    rst = 1'b1;
    req_valid = '0; req_we = '0; resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
    end
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(req_ready[d]), 1);
      check("rst_valid", 32'(resp_valid[d]), 0);
      check("rst_rdata", resp_rdata[d], 0);
      check("rst_err", 32'(resp_err[d]), 0);
    end
    txn(0, 0, 32'h40, 0, 4'h0, 0, 0);
    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    txn(0, 0, 32'h10, 0, 4'h0, 0, 0);
    txn(0, 1, 32'h10, 32'h000000AA, 4'h1, 0, 0);
    txn(0, 0, 32'h10, 0, 4'h0, 0, 0);
    txn(0, 0, 32'h13, 0, 4'h0, 0, 0);
    txn(0, 0, 32'h400, 0, 4'h0, 0, 0);
    txn(0, 1, 32'h400, 32'h12345678, 4'hF, 0, 0);
    txn(0, 0, 32'h0, 0, 4'h0, 0, 0);
    txn(0, 1, 32'h14, 32'hCAFEF00D, 4'h0, 0, 0);
    txn(0, 0, 32'h14, 0, 4'h0, 5, 1);
    txn(1, 1, 32'h10, 32'hA5A55A5A, 4'hF, 2, 0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10; resp_ready[1] = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid[1]) begin
        cnt++;
        check("b2b_rdata", resp_rdata[1], mdl[1][4]);
      end
    end
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    check("b2b_count", 32'(cnt), 10);
    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (r == 7) a = a | 32'($urandom_range(1, 3));
      if (r > 7) a = $urandom | 32'h400;
      txn(int'($urandom_range(0, 1)), 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    txn(0, 1, 32'h20, 32'h55AA55AA, 4'hF, 0, 0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h11223344; req_be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check("rst_mid_ready", 32'(req_ready[0]), 1);
    check("rst_mid_valid", 32'(resp_valid[0]), 0);
    repeat (4) begin
      @(negedge clk);
      check("rst_no_resp", 32'(resp_valid[0]), 0);
    end
    txn(0, 0, 32'h20, 0, 4'h0, 0, 0);
    txn(0, 0, 32'h10, 0, 4'h0, 0, 0);
    txn(1, 0, 32'h10, 0, 4'h0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
